// File: rtl/audio_echo_pkg.sv
// Purpose : shared constants and FSM encoding for the audio echo mixer.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: DECAY_WIDTH / DECAY_SHIFT for the feedback gain (gain = decay/256),
//           state_t encoding of the four-phase sample FSM.
package audio_echo_pkg;

  // Feedback gain is an unsigned 8-bit fraction of 256.
  localparam int DECAY_WIDTH = 8;
  localparam int DECAY_SHIFT = 8;

  // One sample walks IDLE -> READ -> MIX -> OUT -> IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    MIX  = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/echo_delay_ram.sv
// Purpose : simple dual-port delay line storage, one write port, one read port.
// Latency : 1-cycle registered read; write lands on the clock edge.
// Backpressure: none; always accepts reads and writes.
// Ports   : clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request,
//           rd_data registered read result. No reset: contents survive a block reset.
module echo_delay_ram #(
  parameter int data_width = 32,
  parameter int addr_width = 13
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [data_width-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [addr_width-1:0] rd_addr,
  output logic [data_width-1:0] rd_data
);

  logic [data_width-1:0] mem [2**addr_width];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/audio_echo_mixer.sv
// Purpose : stereo echo - each sample is mixed with its decayed copy from one delay lap ago.
// Latency : accept in cycle N, o_valid in cycle N+3; one sample per 4 cycles at best.
// Backpressure: i_ready only while idle; output held in OUT until o_ready.
// Ports   : clk, reset (sync, active-high); input stream i_valid/i_ready/i_is_left/
//           i_audio/i_decay; output stream o_valid/o_ready/o_is_left/o_audio.
module audio_echo_mixer
  import audio_echo_pkg::*;
#(
  parameter int audio_width = 32,
  parameter int delay_log2  = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic                   i_is_left,
  input  logic [audio_width-1:0] i_audio,
  input  logic [DECAY_WIDTH-1:0] i_decay,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic                   o_is_left,
  output logic [audio_width-1:0] o_audio
);

  // Two RAM words per frame: LSB selects channel (0 = left, 1 = right).
  localparam int addr_width = delay_log2 + 1;
  // Arithmetic width: holds sample*decay without loss, so the mix can never wrap.
  localparam int pw = audio_width + DECAY_WIDTH + 1;

  localparam logic [audio_width-1:0] sat_hi = {1'b0, {(audio_width-1){1'b1}}};
  localparam logic [audio_width-1:0] sat_lo = {1'b1, {(audio_width-1){1'b0}}};
  localparam logic signed [pw-1:0] sat_hi_ext = {{(pw-audio_width+1){1'b0}}, {(audio_width-1){1'b1}}};
  localparam logic signed [pw-1:0] sat_lo_ext = {{(pw-audio_width+1){1'b1}}, {(audio_width-1){1'b0}}};

  state_t                   state;
  logic [audio_width-1:0]   sample;
  logic                     is_left;
  logic [DECAY_WIDTH-1:0]   decay;
  logic [delay_log2-1:0]    frame_ptr;
  logic                     primed;

  logic [addr_width-1:0]    ram_addr;
  logic                     ram_rd_en;
  logic                     ram_wr_en;
  logic [audio_width-1:0]   ram_rd_data;

  logic [audio_width-1:0]   delayed;
  logic signed [pw-1:0]     delayed_ext;
  logic signed [pw-1:0]     decay_ext;
  logic signed [pw-1:0]     product;
  logic signed [pw-1:0]     scaled;
  logic signed [pw-1:0]     sample_ext;
  logic signed [pw-1:0]     sum;
  logic [audio_width-1:0]   mixed;

  assign ram_addr  = {frame_ptr, ~is_left};
  assign ram_rd_en = (state == READ);
  // A reset landing on the MIX edge must not commit the aborted sample.
  assign ram_wr_en = (state == MIX) && !reset;

  echo_delay_ram #(
    .data_width (audio_width),
    .addr_width (addr_width)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (ram_addr),
    .wr_data (mixed),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_addr),
    .rd_data (ram_rd_data)
  );

  // Until the pointer has lapped once the RAM holds nothing meaningful.
  assign delayed     = primed ? ram_rd_data : '0;
  assign delayed_ext = {{(pw-audio_width){delayed[audio_width-1]}}, delayed};
  assign decay_ext   = {{(pw-DECAY_WIDTH){1'b0}}, decay};
  assign product     = delayed_ext * decay_ext;
  // Arithmetic shift floors toward -inf, matching a true divide-by-256 floor.
  assign scaled      = product >>> DECAY_SHIFT;
  assign sample_ext  = {{(pw-audio_width){sample[audio_width-1]}}, sample};
  assign sum         = sample_ext + scaled;

  always_comb begin
    mixed = sum[audio_width-1:0];
    if (sum > sat_hi_ext) begin
      mixed = sat_hi;
    end else if (sum < sat_lo_ext) begin
      mixed = sat_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      i_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_is_left <= 1'b1;
      o_audio   <= '0;
      frame_ptr <= '0;
      primed    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            sample  <= i_audio;
            is_left <= i_is_left;
            decay   <= i_decay;
            i_ready <= 1'b0;
            state   <= READ;
          end
        end
        READ: begin
          state <= MIX;
        end
        MIX: begin
          o_audio   <= mixed;
          o_is_left <= is_left;
          o_valid   <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (o_ready) begin
            o_valid <= 1'b0;
            i_ready <= 1'b1;
            state   <= IDLE;
            // Only a finished right sample closes a frame.
            if (!is_left) begin
              frame_ptr <= frame_ptr + 1'b1;
              if (&frame_ptr) begin
                primed <= 1'b1;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/audio_echo_mixer.md
AUDIO_ECHO_MIXER -- requirements
Module: audio_echo_mixer

Interface
REQ-001 Parameters SHALL be:
- audio_width, default 32, signed sample width.
- delay_log2, default 12, log2 of delay length in stereo frames.
REQ-002 Ports SHALL be (clock and reset first):
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- i_valid  in  1  input sample valid.
- i_ready  out  1  block can accept a sample.
- i_is_left  in  1  input sample is the left channel.
- i_audio  in  audio_width  signed input sample.
- i_decay  in  8  unsigned feedback gain, value/256.
- o_valid  out  1  output sample valid.
- o_ready  in  1  downstream accepts.
- o_is_left  out  1  channel of the output sample.
- o_audio  out  audio_width  signed mixed sample.
REQ-003 The block SHALL be the consumer of the serialized L/R stream: one sample per handshake, channel tagged by i_is_left.

Function
REQ-004 FSM states SHALL be IDLE, READ, MIX and OUT.
- i_ready=1 only in IDLE.
- o_valid=1 only in OUT.
REQ-005 IDLE SHALL go to READ on i_valid&&i_ready; the block captures i_audio, i_is_left and i_decay.
REQ-006 READ SHALL issue a delay-RAM read at address {frame_ptr, !is_left} and go to MIX next cycle.
REQ-007 MIX SHALL:
- Compute delayed_scaled = (delayed * decay) >>> 8, signed, arithmetic shift (floor).
- Compute sum = sample + delayed_scaled in audio_width+1 bits.
- Saturate sum to [-2^(audio_width-1), 2^(audio_width-1)-1].
- Register the result as o_audio.
- Write the result to the RAM at the same address.
- Go to OUT.
REQ-008 OUT SHALL hold o_audio and o_is_left stable until o_ready, then go to IDLE; o_valid&&o_ready SHALL never be lost or duplicated.
REQ-009 Minimum latency SHALL be accept at cycle N, o_valid at N+3; maximum throughput one sample per 4 cycles.
REQ-010 frame_ptr (delay_log2 bits) SHALL increment on completion of a right-channel sample, wrapping 2^delay_log2-1 -> 0; left samples SHALL NOT advance it.
REQ-011 The primed flag SHALL be 0 after reset and set when frame_ptr first wraps to 0. While primed=0, delayed SHALL be treated as 0, regardless of RAM contents.
REQ-012 Consecutive same-channel samples SHALL be processed normally; the pointer follows the rule in REQ-010 only, with no resynchronisation.
REQ-013 i_decay=0 SHALL give o_audio=i_audio exactly; i_decay=255 SHALL never overflow (saturation applies).
REQ-014 o_is_left SHALL equal the captured i_is_left of the sample being output.

Reset
REQ-015 On reset the block SHALL set:
- state=IDLE, i_ready=1, o_valid=0, o_is_left=1, o_audio=0.
- frame_ptr=0, primed=0.
REQ-016 Reset asserted in any state SHALL abort the in-flight sample with no output and no further RAM write; RAM contents SHALL NOT be cleared.

Structure
REQ-017 Package audio_echo_pkg SHALL hold DECAY_WIDTH=8, DECAY_SHIFT=8 and the FSM state encoding.
REQ-018 Sub-module echo_delay_ram SHALL be a simple dual-port synchronous RAM, depth 2^(delay_log2+1), width audio_width, 1-cycle registered read and no reset.
REQ-019 Saturation and multiply SHALL be inside audio_echo_mixer; no other sub-modules.

Verification (audio_width=16, delay_log2=2)
REQ-020 Reset -> i_ready=1, o_valid=0, o_is_left=1, o_audio=0.
REQ-021 Send L=1000, R=-1000, decay=128, o_ready=1 -> outputs 1000 (left), -1000 (right), each 3 cycles after accept.
REQ-022 Send 4 zero frames, then L=1000 at frame 0, then 3 zero frames, then L=0, all with decay=128 -> last output 500; the next lap gives 250.
REQ-023 Prime with L=30000, wait 4 frames, send L=30000 with decay=255 -> output 32767 (saturated); repeat the test with negatives -> -32768.
REQ-024 Hold o_ready=0 for 10 cycles in OUT -> o_valid, o_audio and o_is_left stable, i_ready=0; release -> exactly one transfer.
REQ-025 Assert reset during MIX -> no o_valid; the next accepted sample takes the pre-prime path (delayed=0) and o_is_left matches its input.
